pc_fetch_ctrl: RTL and testbench

- Parametrised successor to the current program-counter block.
- Owns the PC register and generates fetch requests to instruction memory.
- Resolves next-PC for jumps and branches, including correct JALR targets.
- Adds a data-stall hold path, misaligned-target trap redirection, a link-address output and a retired-instruction counter.
- Sits between the control unit / ALU flags and the instruction-memory port.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_fetch_ctrl_pkg.sv | 13 +
 rtl/pc_fetch_ctrl_if.sv | 31 +++
 rtl/pc_fetch_ctrl_next.sv | 50 +++++
 rtl/pc_fetch_ctrl.sv | 104 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 198 +++++++++++++++++++
 6 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide definitions: decoded operation type and default datapath width.
package cpu_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [4:0] {
        CU_ERROR,
        CU_ADDI,
        CU_ADD,
        CU_LUI,
        CU_LW,
        CU_SW,
        CU_JAL,
        CU_JALR,
        CU_BEQ,
        CU_BNE,
        CU_BLT,
        CU_BGE,
        CU_BLTU,
        CU_BGEU
    } cuOPType;

endpackage

// File: rtl/pc_fetch_ctrl_pkg.sv
// Local definitions for the PC / fetch controller.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        WAIT,
        TRAP
    } fetch_state_e;

    localparam logic [31:0] TRAP_VECTOR_DEF = 32'h0000_0100;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bundle between control unit / ALU flags, instruction memory and fetch controller.
interface pc_fetch_ctrl_if #(
    parameter int XLEN  = cpu_pkg::XLEN_DEF,
    parameter int CNT_W = 32
) ();

    cpu_pkg::cuOPType  cu_op;
    logic [XLEN-1:0]   rs1_read;
    logic [XLEN-1:0]   imm;
    logic              alu_neg;
    logic              zero;
    logic              iready;
    logic              stall;
    logic              ireq;
    logic [XLEN-1:0]   iaddr;
    logic [XLEN-1:0]   link_addr;
    logic [CNT_W-1:0]  instret;
    logic              misalign;
    logic [XLEN-1:0]   bad_addr;

    modport master (
        input  cu_op, rs1_read, imm, alu_neg, zero, iready, stall,
        output ireq, iaddr, link_addr, instret, misalign, bad_addr
    );

    modport slave (
        output cu_op, rs1_read, imm, alu_neg, zero, iready, stall,
        input  ireq, iaddr, link_addr, instret, misalign, bad_addr
    );

endinterface

// File: rtl/pc_fetch_ctrl_next.sv
// Combinational next-PC mux and target misalignment check.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  cuOPType          op_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             alu_neg_i,
    input  logic             zero_i,
    output logic [XLEN-1:0]  next_pc_o,
    output logic             misalign_o
);

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] rel_pc;
    logic [XLEN-1:0] reg_sum;
    logic            take;

    assign seq_pc  = pc_i + XLEN'(4);
    assign rel_pc  = pc_i + imm_i;
    assign reg_sum = rs1_i + imm_i;

    always_comb begin
        take = 1'b0;
        case (op_i)
            CU_JAL:  take = 1'b1;
            CU_BEQ:  take = zero_i;
            CU_BNE:  take = ~zero_i;
            CU_BLT,
            CU_BLTU: take = alu_neg_i;
            CU_BGE,
            CU_BGEU: take = ~alu_neg_i;
            default: take = 1'b0;
        endcase
    end

    // JALR clears bit 0 of the register-relative target
    always_comb begin
        next_pc_o = take ? rel_pc : seq_pc;
        if (op_i == CU_JALR) begin
            next_pc_o = {reg_sum[XLEN-1:1], 1'b0};
        end
    end

    assign misalign_o = |next_pc_o[1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch-request sequencer with stall hold and misaligned-target trap.
module pc_fetch_ctrl
    import cpu_pkg::*;
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int              CNT_W        = 32
) (
    input  logic            clk,
    input  logic            RST,
    pc_fetch_ctrl_if.master bus
);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pend_q, pend_d;
    logic [XLEN-1:0]  bad_q, bad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  next_pc;
    logic             tgt_mis;
    logic             ireq_w;
    logic             mis_w;

    pc_next_calc #(
        .XLEN(XLEN)
    ) u_next (
        .op_i      (bus.cu_op),
        .pc_i      (pc_q),
        .rs1_i     (bus.rs1_read),
        .imm_i     (bus.imm),
        .alu_neg_i (bus.alu_neg),
        .zero_i    (bus.zero),
        .next_pc_o (next_pc),
        .misalign_o(tgt_mis)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            pend_q  <= '0;
            bad_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        ireq_w  = 1'b0;
        mis_w   = 1'b0;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                ireq_w = 1'b1;
                // trap outranks stall so a bad target never parks in WAIT
                if (bus.iready) begin
                    if (tgt_mis) begin
                        pc_d    = TRAP_VECTOR;
                        bad_d   = next_pc;
                        state_d = TRAP;
                    end else if (bus.stall) begin
                        pend_d  = next_pc;
                        state_d = WAIT;
                    end else begin
                        pc_d  = next_pc;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (!bus.stall) begin
                    pc_d    = pend_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = FETCH;
                end
            end
            TRAP: begin
                mis_w   = 1'b1;
                state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase
    end

    assign bus.ireq      = ireq_w;
    assign bus.misalign  = mis_w;
    assign bus.iaddr     = pc_q;
    assign bus.link_addr = pc_q + XLEN'(4);
    assign bus.instret   = cnt_q;
    assign bus.bad_addr  = bad_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized run.
module tb_pc_fetch_ctrl;
    import cpu_pkg::*;

    localparam int          XLEN = 32;
    localparam int          CW   = 8;
    localparam logic [31:0] TVEC = 32'h100;

    logic clk = 1'b0;
    logic RST = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [CW-1:0] exp_cnt;

    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

    pc_fetch_ctrl #(
        .XLEN(XLEN), .RESET_VECTOR(32'h0),
        .TRAP_VECTOR(TVEC), .CNT_W(CW)
    ) dut (
        .clk(clk), .RST(RST), .bus(bus)
    );

    task automatic drive(input cuOPType op, input logic [31:0] im,
                         input logic [31:0] r1, input logic ng,
                         input logic z, input logic rdy, input logic st);
        bus.cu_op = op; bus.imm = im; bus.rs1_read = r1;
        bus.alu_neg = ng; bus.zero = z; bus.iready = rdy; bus.stall = st;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference target straight from the jump/branch rules
    function automatic logic [31:0] ref_target(cuOPType op, logic [31:0] pc,
            logic [31:0] r1, logic [31:0] im, logic ng, logic z);
        bit taken;
        if (op == CU_JALR) return (r1 + im) & 32'hFFFF_FFFE;
        taken = (op == CU_JAL) || (op == CU_BEQ && z) || (op == CU_BNE && !z)
             || ((op == CU_BLT || op == CU_BLTU) && ng)
             || ((op == CU_BGE || op == CU_BGEU) && !ng);
        return taken ? pc + im : pc + 32'd4;
    endfunction

    task automatic test_reset();
        drive(CU_ADDI, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        cyc(); cyc();
        n_chk++; if (bus.ireq !== 1'b0) begin n_fail++; $display("FAIL rst_ireq got=%b exp=0", bus.ireq); end
        n_chk++; if (bus.iaddr !== 32'h0) begin n_fail++; $display("FAIL rst_iaddr got=%h exp=0", bus.iaddr); end
        n_chk++; if (bus.instret !== '0) begin n_fail++; $display("FAIL rst_instret got=%0d exp=0", bus.instret); end
        n_chk++; if (bus.bad_addr !== 32'h0 || bus.misalign !== 1'b0) begin n_fail++; $display("FAIL rst_trap bad=%h mis=%b exp=0/0", bus.bad_addr, bus.misalign); end
        RST = 1'b0;
        #1;
        n_chk++; if (bus.ireq !== 1'b0) begin n_fail++; $display("FAIL boot_ireq got=%b exp=0", bus.ireq); end
        @(negedge clk);
        cyc();
        n_chk++; if (bus.ireq !== 1'b1 || bus.iaddr !== 32'h0) begin n_fail++; $display("FAIL fetch0 ireq=%b iaddr=%h exp=1/0", bus.ireq, bus.iaddr); end
        n_chk++; if (bus.instret !== '0) begin n_fail++; $display("FAIL fetch0_cnt got=%0d exp=0", bus.instret); end
        exp_cnt = '0;
    endtask

    task automatic test_sequential();
        drive(CU_ADDI, 32'h7, 32'h55, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (bus.iaddr !== 32'(4 * i) || bus.link_addr !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL seq_%0d iaddr=%h link=%h exp=%h", i, bus.iaddr, bus.link_addr, 4 * i); end
            cyc();
            exp_cnt++;
        end
        n_chk++; if (bus.iaddr !== 32'h10 || bus.instret !== 8'd4) begin n_fail++; $display("FAIL seq_end iaddr=%h cnt=%0d exp=10/4", bus.iaddr, bus.instret); end
    endtask

    task automatic step_to(input cuOPType op, input logic [31:0] im,
                           input logic [31:0] r1, input logic ng, input logic z,
                           input logic [31:0] exp_pc, input string tag);
        drive(op, im, r1, ng, z, 1, 0);
        cyc();
        exp_cnt++;
        n_chk++; if (bus.iaddr !== exp_pc || bus.instret !== exp_cnt) begin n_fail++; $display("FAIL %s iaddr=%h cnt=%0d exp=%h/%0d", tag, bus.iaddr, bus.instret, exp_pc, exp_cnt); end
    endtask

    task automatic test_branches();
        drive(CU_ADD, 0, 0, 0, 0, 1, 0);
        repeat (4) begin cyc(); exp_cnt++; end
        n_chk++; if (bus.iaddr !== 32'h20) begin n_fail++; $display("FAIL br_setup iaddr=%h exp=20", bus.iaddr); end
        step_to(CU_BEQ, 32'hFFFF_FFF0, 0, 0, 1, 32'h10, "beq_taken");
        step_to(CU_JAL, 32'h10, 0, 0, 0, 32'h20, "jal_fwd");
        step_to(CU_BEQ, 32'hFFFF_FFF0, 0, 0, 0, 32'h24, "beq_not");
        step_to(CU_JAL, 32'hFFFF_FFFC, 0, 0, 0, 32'h20, "jal_back");
        step_to(CU_BGE, 32'hFFFF_FFF0, 0, 1, 0, 32'h24, "bge_not");
        drive(CU_JAL, 32'h40, 0, 0, 0, 0, 0);
        cyc(); cyc();
        n_chk++; if (bus.iaddr !== 32'h24 || bus.instret !== exp_cnt) begin n_fail++; $display("FAIL idle_hold iaddr=%h cnt=%0d exp=24/%0d", bus.iaddr, bus.instret, exp_cnt); end
    endtask

    task automatic test_jalr();
        n_chk++; if (bus.link_addr !== 32'h28) begin n_fail++; $display("FAIL jalr_link got=%h exp=28", bus.link_addr); end
        step_to(CU_JALR, 32'h2, 32'h1003, 0, 0, 32'h1004, "jalr");
        n_chk++; if (bus.link_addr !== 32'h1008 || bus.misalign !== 1'b0) begin n_fail++; $display("FAIL jalr_after link=%h mis=%b exp=1008/0", bus.link_addr, bus.misalign); end
    endtask

    task automatic test_stall();
        step_to(CU_JAL, 32'hFFFF_F004, 0, 0, 0, 32'h8, "to_8");
        drive(CU_JAL, 32'h40, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_chk++; if (bus.ireq !== 1'b0 || bus.iaddr !== 32'h8 || bus.instret !== exp_cnt) begin n_fail++; $display("FAIL stall_%0d ireq=%b iaddr=%h cnt=%0d exp=0/8/%0d", i, bus.ireq, bus.iaddr, bus.instret, exp_cnt); end
            drive(CU_JAL, 32'h400, 0, 0, 0, 1, 1);
        end
        drive(CU_JAL, 32'h400, 0, 0, 0, 0, 0);
        cyc();
        exp_cnt++;
        n_chk++; if (bus.ireq !== 1'b1 || bus.iaddr !== 32'h48 || bus.instret !== exp_cnt) begin n_fail++; $display("FAIL stall_rel ireq=%b iaddr=%h cnt=%0d exp=1/48/%0d", bus.ireq, bus.iaddr, bus.instret, exp_cnt); end
        cyc();
        n_chk++; if (bus.iaddr !== 32'h48 || bus.instret !== exp_cnt) begin n_fail++; $display("FAIL stall_once iaddr=%h cnt=%0d exp=48/%0d", bus.iaddr, bus.instret, exp_cnt); end
    endtask

    task automatic test_trap();
        step_to(CU_JAL, 32'hFFFF_FFB8, 0, 0, 0, 32'h0, "to_0");
        drive(CU_JAL, 32'h6, 0, 0, 0, 1, 1);
        cyc();
        n_chk++; if (bus.misalign !== 1'b1 || bus.ireq !== 1'b0) begin n_fail++; $display("FAIL trap_pulse mis=%b ireq=%b exp=1/0", bus.misalign, bus.ireq); end
        n_chk++; if (bus.bad_addr !== 32'h6 || bus.iaddr !== TVEC || bus.instret !== exp_cnt) begin n_fail++; $display("FAIL trap_state bad=%h iaddr=%h cnt=%0d exp=6/100/%0d", bus.bad_addr, bus.iaddr, bus.instret, exp_cnt); end
        drive(CU_ADDI, 0, 0, 0, 0, 0, 0);
        cyc();
        n_chk++; if (bus.misalign !== 1'b0 || bus.ireq !== 1'b1 || bus.iaddr !== TVEC) begin n_fail++; $display("FAIL trap_after mis=%b ireq=%b iaddr=%h exp=0/1/100", bus.misalign, bus.ireq, bus.iaddr); end
        drive(CU_JAL, 32'h40, 0, 0, 0, 1, 1);
        cyc(); cyc();
        n_chk++; if (bus.ireq !== 1'b0) begin n_fail++; $display("FAIL wait_pre ireq=%b exp=0", bus.ireq); end
        RST = 1'b1;
        #1;
        n_chk++; if (bus.iaddr !== 32'h0 || bus.instret !== '0 || bus.bad_addr !== 32'h0) begin n_fail++; $display("FAIL rst_wait iaddr=%h cnt=%0d bad=%h exp=0", bus.iaddr, bus.instret, bus.bad_addr); end
        drive(CU_ADDI, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        RST = 1'b0;
        cyc(); cyc();
        n_chk++; if (bus.ireq !== 1'b1 || bus.iaddr !== 32'h0) begin n_fail++; $display("FAIL rst_wait_resume ireq=%b iaddr=%h exp=1/0", bus.ireq, bus.iaddr); end
    endtask

    task automatic test_random();
        cuOPType ops[14] = '{CU_ERROR, CU_ADDI, CU_ADD, CU_LUI, CU_LW, CU_SW,
            CU_JAL, CU_JALR, CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU};
        logic [31:0] m_pc = 32'h0, m_pend = 32'h0, m_bad = 32'h0, t, im;
        logic [CW-1:0] m_cnt = '0;
        bit m_wait = 0, m_trap = 0;
        cuOPType op;
        logic rdy, st, ng, z;
        for (int i = 0; i < 700; i++) begin
            n_chk++;
            if (bus.ireq !== !(m_wait || m_trap) || bus.iaddr !== m_pc
                || bus.link_addr !== m_pc + 32'd4 || bus.instret !== m_cnt
                || bus.misalign !== m_trap || bus.bad_addr !== m_bad) begin
                n_fail++;
                $display("FAIL rnd_%0d ireq=%b iaddr=%h cnt=%0d mis=%b bad=%h exp=%b/%h/%0d/%b/%h",
                    i, bus.ireq, bus.iaddr, bus.instret, bus.misalign, bus.bad_addr,
                    !(m_wait || m_trap), m_pc, m_cnt, m_trap, m_bad);
            end
            op  = ops[$urandom_range(0, 13)];
            im  = 32'($urandom_range(0, 63) * 4) - 32'd128;
            if ($urandom_range(0, 9) == 0) im = im + 32'($urandom_range(1, 3));
            rdy = ($urandom_range(0, 9) < 8);
            st  = ($urandom_range(0, 3) == 0);
            ng  = 1'($urandom);
            z   = 1'($urandom);
            drive(op, im, $urandom, ng, z, rdy, st);
            if (m_trap) begin
                m_trap = 0;
            end else if (m_wait) begin
                if (!st) begin m_pc = m_pend; m_cnt++; m_wait = 0; end
            end else if (rdy) begin
                t = ref_target(op, m_pc, bus.rs1_read, im, ng, z);
                if (t[1:0] != 2'b00) begin m_bad = t; m_pc = TVEC; m_trap = 1; end
                else if (st) begin m_pend = t; m_wait = 1; end
                else begin m_pc = t; m_cnt++; end
            end
            cyc();
        end
    endtask

    initial begin
        drive(CU_ADDI, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branches();
        test_jalr();
        test_stall();
        test_trap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
